// File: rtl/uart_dbg_master_pkg.sv
// Shared encodings for the UART debug bus master: FSM states, default opcodes, ACK byte.
package uart_dbg_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    REQ  = 3'd3,
    BUS  = 3'd4,
    TX   = 3'd5,
    ACK  = 3'd6
  } state_t;

  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;
  localparam logic [7:0] ACK_BYTE      = 8'h06;

endpackage

// File: rtl/uart_dbg_master_txser.sv
// Serialises up to four bytes of a word (LSB first) to the UART transmitter, pacing on txdBusy_i.
module uart_dbg_txser
  import uart_dbg_master_pkg::*;
(
  input  logic        clk25,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] word,
  input  logic [1:0]  last_idx,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        done
);

  logic        active;
  logic        gap;
  logic [1:0]  remain;
  logic [31:0] shreg;

  always_ff @(posedge clk25) begin
    if (rst) begin
      active     <= 1'b0;
      gap        <= 1'b0;
      remain     <= 2'd0;
      shreg      <= 32'h0;
      txdStart_o <= 1'b0;
      txdData_o  <= 8'h00;
      done       <= 1'b0;
    end else begin
      txdStart_o <= 1'b0;
      done       <= 1'b0;
      gap        <= 1'b0;
      if (start) begin
        active <= 1'b1;
        remain <= last_idx;
        shreg  <= word;
      end else if (active && !gap && !txdBusy_i) begin
        // gap skips one cycle so the transmitter can raise busy after the strobe
        txdStart_o <= 1'b1;
        txdData_o  <= shreg[7:0];
        shreg      <= {8'h00, shreg[31:8]};
        gap        <= 1'b1;
        if (remain == 2'd0) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          remain <= remain - 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_dbg_master.sv
// UART-driven second bus initiator: parses W/R packets and issues single 32-bit accesses.
// Define UART_DBG_ACK_EN to return an ACK byte (8'h06) after every completed write.
module uart_dbg_master
  import uart_dbg_master_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0] CMD_WRITE      = CMD_WRITE_DEF,
  parameter logic [7:0] CMD_READ       = CMD_READ_DEF
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        busReq_o,
  input  logic        busGnt_i,
  output logic        devEnable_o,
  output logic        devWrite_o,
  input  logic        devBusy_i,
  output logic [31:0] devPhysicalAddr_o,
  output logic [31:0] devDataSave_o,
  input  logic [31:0] devDataLoad_i,
  output logic [3:0]  devByteSelect_o
);
  // state | meaning
  // IDLE  | waiting for an opcode byte
  // ADDR  | collecting 4 address bytes, LSB first
  // DATA  | collecting 4 write-data bytes, LSB first
  // REQ   | requesting the device bus, waiting for grant
  // BUS   | access in flight until devBusy_i is low
  // TX    | returning the 4 read-data bytes
  // ACK   | returning the write acknowledge byte

  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          is_write;
  logic          opcode_ok;
  logic          tmo_hit;
  logic          ser_start;
  logic          ser_done;
  logic [31:0]   ser_word;
  logic [1:0]    ser_last;

  assign opcode_ok       = (rxdData_i == CMD_WRITE) || (rxdData_i == CMD_READ);
  assign tmo_hit         = (tmo_cnt == TMO_LAST);
  assign devByteSelect_o = 4'hf;

  always_ff @(posedge clk25) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ser_start = 1'b0;
    ser_word  = devDataLoad_i;
    ser_last  = 2'd3;
    unique case (state)
      IDLE: if (rxdReady_i && opcode_ok) state_nx = ADDR;
      ADDR: begin
        if (rxdReady_i) begin
          if (byte_cnt == 2'd3) state_nx = is_write ? DATA : REQ;
        end else if (tmo_hit) begin
          state_nx = IDLE;
        end
      end
      DATA: begin
        if (rxdReady_i) begin
          if (byte_cnt == 2'd3) state_nx = REQ;
        end else if (tmo_hit) begin
          state_nx = IDLE;
        end
      end
      REQ: if (busGnt_i) state_nx = BUS;
      BUS: begin
        if (!devBusy_i) begin
          if (!is_write) begin
            state_nx  = TX;
            ser_start = 1'b1;
          end
`ifdef UART_DBG_ACK_EN
          else begin
            state_nx  = ACK;
            ser_start = 1'b1;
            ser_word  = {24'h0, ACK_BYTE};
            ser_last  = 2'd0;
          end
`else
          else begin
            state_nx = IDLE;
          end
`endif
        end
      end
      TX: if (ser_done) state_nx = IDLE;
`ifdef UART_DBG_ACK_EN
      ACK: if (ser_done) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      byte_cnt          <= 2'd0;
      tmo_cnt           <= '0;
      is_write          <= 1'b0;
      devPhysicalAddr_o <= 32'h0;
      devDataSave_o     <= 32'h0;
      busReq_o          <= 1'b0;
      devEnable_o       <= 1'b0;
      devWrite_o        <= 1'b0;
    end else begin
      // bus controls are registered from the next state so they line up with it
      busReq_o    <= (state_nx == REQ) || (state_nx == BUS);
      devEnable_o <= (state_nx == BUS);
      devWrite_o  <= (state_nx == BUS) && is_write;

      if ((state == ADDR || state == DATA) && !rxdReady_i && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (rxdReady_i) begin
        if (state == IDLE && opcode_ok) begin
          is_write <= (rxdData_i == CMD_WRITE);
          byte_cnt <= 2'd0;
        end else if (state == ADDR) begin
          devPhysicalAddr_o <= {rxdData_i, devPhysicalAddr_o[31:8]};
          byte_cnt          <= byte_cnt + 2'd1;
        end else if (state == DATA) begin
          devDataSave_o <= {rxdData_i, devDataSave_o[31:8]};
          byte_cnt      <= byte_cnt + 2'd1;
        end
      end
    end
  end

  uart_dbg_txser u_txser (
    .clk25      (clk25),
    .rst        (rst),
    .start      (ser_start),
    .word       (ser_word),
    .last_idx   (ser_last),
    .txdBusy_i  (txdBusy_i),
    .txdStart_o (txdStart_o),
    .txdData_o  (txdData_o),
    .done       (ser_done)
  );

endmodule
